// File: rtl/frame_packetizer.sv
// Cuts a raw AXI-Stream into packets within frames, forwarding data with TLAST
// per packet and emitting one metadata beat per packet through a small FIFO.
module frame_packetizer #(
   parameter int unsigned DW       = 512,
   parameter int unsigned MD_DEPTH = 4
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic [31:0]   FRAME_SIZE,
   input  logic [31:0]   PACKET_SIZE,
   input  logic [DW-1:0] AXIS_IN_TDATA,
   input  logic          AXIS_IN_TVALID,
   output logic          AXIS_IN_TREADY,
   output logic [DW-1:0] AXIS_OUT_FD_TDATA,
   output logic          AXIS_OUT_FD_TVALID,
   input  logic          AXIS_OUT_FD_TREADY,
   output logic          AXIS_OUT_FD_TLAST,
   output logic [DW-1:0] AXIS_OUT_MD_TDATA,
   output logic          AXIS_OUT_MD_TVALID,
   input  logic          AXIS_OUT_MD_TREADY,
   output logic          CFG_ERR,
   output logic [31:0]   FRAME_CNT
);
   localparam int unsigned BPB = DW / 8;
   localparam int unsigned AW  = $clog2(MD_DEPTH);
   localparam int unsigned MDW = 98;

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_ERR} state_e;

   state_e        state_q, state_d;
   logic          run_q;
   logic [31:0]   frame_rem_q, frame_rem_d;
   logic [31:0]   pkt_rem_q, pkt_rem_d;
   logic [31:0]   pkt_size_q, pkt_size_d;
   logic [31:0]   pkt_idx_q, pkt_idx_d;
   logic [31:0]   frame_cnt_q, frame_cnt_d;
   logic          cfg_err_q, cfg_err_d;

   logic          out_v_q, out_v_d, skid_v_q, skid_v_d;
   logic [DW:0]   out_q, out_d, skid_q, skid_d;

   logic [MDW-1:0] md_mem_q [MD_DEPTH];
   logic [AW-1:0]  md_wr_q, md_rd_q;
   logic [AW:0]    md_cnt_q;

   logic          cfg_ok, pkt_first, tlast, frame_last;
   logic          in_ready, in_hs, md_full, md_pop, md_push, fd_pop;
   logic [31:0]   cur_frame_rem, cur_pkt_size, cur_pkt_rem, pkt_len;
   logic [MDW-1:0] md_entry;

   // Frame/packet bookkeeping; in IDLE the live config inputs stand in for the held ones
   always_comb begin
      cfg_ok = (FRAME_SIZE != 32'd0) && (PACKET_SIZE != 32'd0) &&
               ((FRAME_SIZE % 32'(BPB)) == 32'd0) && ((PACKET_SIZE % 32'(BPB)) == 32'd0) &&
               (PACKET_SIZE <= FRAME_SIZE);
      cur_frame_rem = (state_q == S_IDLE) ? FRAME_SIZE  : frame_rem_q;
      cur_pkt_size  = (state_q == S_IDLE) ? PACKET_SIZE : pkt_size_q;
      pkt_first     = (state_q == S_IDLE) || (pkt_rem_q == 32'd0);
      pkt_len       = (cur_pkt_size < cur_frame_rem) ? cur_pkt_size : cur_frame_rem;
      cur_pkt_rem   = pkt_first ? pkt_len : pkt_rem_q;
      tlast         = (cur_pkt_rem == 32'(BPB));
      frame_last    = (cur_frame_rem == 32'(BPB));
      md_entry      = {pkt_len == cur_frame_rem, state_q == S_IDLE, pkt_len, pkt_idx_q, frame_cnt_q};
   end

   assign md_full  = (md_cnt_q == (AW+1)'(MD_DEPTH));
   assign md_pop   = AXIS_OUT_MD_TVALID && AXIS_OUT_MD_TREADY;
   assign fd_pop   = out_v_q && AXIS_OUT_FD_TREADY;
   assign in_ready = run_q && !skid_v_q && (!pkt_first || !md_full || md_pop) &&
                     (state_q != S_ERR) && ((state_q != S_IDLE) || cfg_ok);
   assign in_hs    = AXIS_IN_TVALID && in_ready;
   assign md_push  = in_hs && pkt_first;

   always_comb begin
      state_d     = state_q;
      frame_rem_d = frame_rem_q;
      pkt_rem_d   = pkt_rem_q;
      pkt_size_d  = pkt_size_q;
      pkt_idx_d   = pkt_idx_q;
      frame_cnt_d = frame_cnt_q;
      cfg_err_d   = cfg_err_q;
      case (state_q)
         S_IDLE: begin
            if (run_q && AXIS_IN_TVALID && !cfg_ok) begin
               state_d   = S_ERR;
               cfg_err_d = 1'b1;
            end
         end
         default: ;
      endcase
      if (in_hs) begin
         frame_rem_d = cur_frame_rem - 32'(BPB);
         pkt_rem_d   = cur_pkt_rem - 32'(BPB);
         pkt_size_d  = cur_pkt_size;
         if (frame_last) begin
            state_d     = S_IDLE;
            frame_cnt_d = frame_cnt_q + 32'd1;
            pkt_idx_d   = 32'd0;
         end else begin
            state_d = S_STREAM;
            if (tlast) pkt_idx_d = pkt_idx_q + 32'd1;
         end
      end
   end

   // Two-entry skid buffer; input only accepted while the skid slot is free
   always_comb begin
      out_v_d  = out_v_q;
      out_d    = out_q;
      skid_v_d = skid_v_q;
      skid_d   = skid_q;
      if (!out_v_q || fd_pop) begin
         if (skid_v_q) begin
            out_v_d  = 1'b1;
            out_d    = skid_q;
            skid_v_d = 1'b0;
         end else begin
            out_v_d = in_hs;
            if (in_hs) out_d = {tlast, AXIS_IN_TDATA};
         end
      end else if (in_hs) begin
         skid_v_d = 1'b1;
         skid_d   = {tlast, AXIS_IN_TDATA};
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         run_q       <= 1'b0;
         frame_rem_q <= '0;
         pkt_rem_q   <= '0;
         pkt_size_q  <= '0;
         pkt_idx_q   <= '0;
         frame_cnt_q <= '0;
         cfg_err_q   <= 1'b0;
         out_v_q     <= 1'b0;
         out_q       <= '0;
         skid_v_q    <= 1'b0;
         skid_q      <= '0;
      end else begin
         state_q     <= state_d;
         run_q       <= 1'b1;
         frame_rem_q <= frame_rem_d;
         pkt_rem_q   <= pkt_rem_d;
         pkt_size_q  <= pkt_size_d;
         pkt_idx_q   <= pkt_idx_d;
         frame_cnt_q <= frame_cnt_d;
         cfg_err_q   <= cfg_err_d;
         out_v_q     <= out_v_d;
         out_q       <= out_d;
         skid_v_q    <= skid_v_d;
         skid_q      <= skid_d;
      end
   end

   // Metadata FIFO; a pop in the same cycle frees the slot for a push when full
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < int'(MD_DEPTH); i++) md_mem_q[i] <= '0;
         md_wr_q  <= '0;
         md_rd_q  <= '0;
         md_cnt_q <= '0;
      end else begin
         if (md_push) begin
            md_mem_q[md_wr_q] <= md_entry;
            md_wr_q           <= md_wr_q + AW'(1);
         end
         if (md_pop) md_rd_q <= md_rd_q + AW'(1);
         case ({md_push, md_pop})
            2'b10:   md_cnt_q <= md_cnt_q + (AW+1)'(1);
            2'b01:   md_cnt_q <= md_cnt_q - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   assign AXIS_IN_TREADY     = in_ready;
   assign AXIS_OUT_FD_TVALID = out_v_q;
   assign AXIS_OUT_FD_TLAST  = out_q[DW];
   assign AXIS_OUT_FD_TDATA  = out_q[DW-1:0];
   assign AXIS_OUT_MD_TVALID = (md_cnt_q != '0);
   assign AXIS_OUT_MD_TDATA  = DW'(md_mem_q[md_rd_q]);
   assign CFG_ERR            = cfg_err_q;
   assign FRAME_CNT          = frame_cnt_q;
endmodule

// File: tb/tb_frame_packetizer.sv
// Scoreboard bench for frame_packetizer: expected FD beats and MD entries are
// queued when frames are generated and compared as the outputs hand them off.
module tb_frame_packetizer;
   localparam int unsigned DW  = 512;
   localparam int unsigned BPB = DW / 8;

   logic          clk = 1'b0;
   logic          resetn;
   logic [31:0]   FRAME_SIZE, PACKET_SIZE;
   logic [DW-1:0] AXIS_IN_TDATA;
   logic          AXIS_IN_TVALID, AXIS_IN_TREADY;
   logic [DW-1:0] AXIS_OUT_FD_TDATA;
   logic          AXIS_OUT_FD_TVALID, AXIS_OUT_FD_TREADY, AXIS_OUT_FD_TLAST;
   logic [DW-1:0] AXIS_OUT_MD_TDATA;
   logic          AXIS_OUT_MD_TVALID, AXIS_OUT_MD_TREADY;
   logic          CFG_ERR;
   logic [31:0]   FRAME_CNT;

   frame_packetizer #(.DW(DW), .MD_DEPTH(4)) dut (
      .clk(clk), .resetn(resetn),
      .FRAME_SIZE(FRAME_SIZE), .PACKET_SIZE(PACKET_SIZE),
      .AXIS_IN_TDATA(AXIS_IN_TDATA), .AXIS_IN_TVALID(AXIS_IN_TVALID), .AXIS_IN_TREADY(AXIS_IN_TREADY),
      .AXIS_OUT_FD_TDATA(AXIS_OUT_FD_TDATA), .AXIS_OUT_FD_TVALID(AXIS_OUT_FD_TVALID),
      .AXIS_OUT_FD_TREADY(AXIS_OUT_FD_TREADY), .AXIS_OUT_FD_TLAST(AXIS_OUT_FD_TLAST),
      .AXIS_OUT_MD_TDATA(AXIS_OUT_MD_TDATA), .AXIS_OUT_MD_TVALID(AXIS_OUT_MD_TVALID),
      .AXIS_OUT_MD_TREADY(AXIS_OUT_MD_TREADY),
      .CFG_ERR(CFG_ERR), .FRAME_CNT(FRAME_CNT)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] stim_q[$];
   logic [DW:0]   fd_q[$];
   logic [DW-1:0] md_q[$];
   int            n_checks = 0, n_fail = 0;
   int            cyc = 0, n_acc = 0, first_acc = -1, last_acc = -1;
   logic [31:0]   tb_frame_no = 0;
   logic          fd_rand = 1'b0, md_en = 1'b1;
   logic          fd_hold_v = 1'b0, md_hold_v = 1'b0;
   logic [DW:0]   fd_hold;
   logic [DW-1:0] md_hold;

   task automatic check(input string tag, input logic [DW+1:0] got, input logic [DW+1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference packetizing: each beat's packet is located from its byte offset
   task automatic queue_frame(input int unsigned fsz, input int unsigned psz);
      for (int unsigned b = 0; b < fsz / BPB; b++) begin
         logic [DW-1:0] d, m;
         int unsigned   off, idx, start, len;
         for (int w = 0; w < int'(DW / 32); w++) d[w*32 +: 32] = $urandom;
         d[31:0]  = b;
         d[63:32] = tb_frame_no;
         off   = b * BPB;
         idx   = off / psz;
         start = idx * psz;
         len   = (fsz - start < psz) ? fsz - start : psz;
         stim_q.push_back(d);
         fd_q.push_back({(off + BPB == start + len), d});
         if (off == start) begin
            m          = '0;
            m[31:0]    = tb_frame_no;
            m[63:32]   = idx;
            m[95:64]   = len;
            m[96]      = (idx == 0);
            m[97]      = (start + len == fsz);
            md_q.push_back(m);
         end
      end
      tb_frame_no++;
   endtask

   task automatic step();
      @(negedge clk);
      AXIS_IN_TVALID     = (stim_q.size() > 0);
      AXIS_IN_TDATA      = (stim_q.size() > 0) ? stim_q[0] : '0;
      AXIS_OUT_FD_TREADY = fd_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      AXIS_OUT_MD_TREADY = md_en;
      #4;
      cyc++;
      if (AXIS_IN_TVALID && AXIS_IN_TREADY) begin
         stim_q.delete(0);
         n_acc++;
         last_acc = cyc;
         if (first_acc < 0) first_acc = cyc;
      end
      if (fd_hold_v)
         check("fd_stable", {AXIS_OUT_FD_TVALID, AXIS_OUT_FD_TLAST, AXIS_OUT_FD_TDATA}, {1'b1, fd_hold});
      fd_hold_v = 1'b0;
      if (AXIS_OUT_FD_TVALID) begin
         if (AXIS_OUT_FD_TREADY) begin
            if (fd_q.size() == 0) check("fd_extra", 1, 0);
            else begin
               check("fd_data", AXIS_OUT_FD_TDATA, fd_q[0][DW-1:0]);
               check("fd_last", AXIS_OUT_FD_TLAST, fd_q[0][DW]);
               fd_q.delete(0);
            end
         end else begin
            fd_hold_v = 1'b1;
            fd_hold   = {AXIS_OUT_FD_TLAST, AXIS_OUT_FD_TDATA};
         end
      end
      if (md_hold_v) check("md_stable", {AXIS_OUT_MD_TVALID, AXIS_OUT_MD_TDATA}, {1'b1, md_hold});
      md_hold_v = 1'b0;
      if (AXIS_OUT_MD_TVALID) begin
         if (AXIS_OUT_MD_TREADY) begin
            if (md_q.size() == 0) check("md_extra", 1, 0);
            else begin
               check("md_data", AXIS_OUT_MD_TDATA, md_q[0]);
               md_q.delete(0);
            end
         end else begin
            md_hold_v = 1'b1;
            md_hold   = AXIS_OUT_MD_TDATA;
         end
      end
   endtask

   task automatic drain(input string tag, input int max_cyc);
      int n = 0;
      while ((stim_q.size() + fd_q.size() + md_q.size()) > 0 && n < max_cyc) begin
         step();
         n++;
      end
      check({tag, "_pending"}, stim_q.size() + fd_q.size() + md_q.size(), 0);
      repeat (3) step();
   endtask

   task automatic do_reset(input string tag);
      AXIS_IN_TVALID = 1'b0;
      @(negedge clk);
      resetn = 1'b0;
      #1;
      check({tag, "_ctrl"}, {AXIS_OUT_FD_TVALID, AXIS_OUT_FD_TLAST, AXIS_OUT_MD_TVALID,
                             AXIS_IN_TREADY, CFG_ERR, FRAME_CNT}, '0);
      check({tag, "_fd_data"}, AXIS_OUT_FD_TDATA, '0);
      check({tag, "_md_data"}, AXIS_OUT_MD_TDATA, '0);
      stim_q.delete();
      fd_q.delete();
      md_q.delete();
      fd_hold_v   = 1'b0;
      md_hold_v   = 1'b0;
      tb_frame_no = 0;
      fd_rand     = 1'b0;
      md_en       = 1'b1;
      repeat (2) @(negedge clk);
      check({tag, "_rdy"}, AXIS_IN_TREADY, 0);
      resetn = 1'b1;
   endtask

   initial begin
      resetn = 1'b1;
      AXIS_IN_TVALID = 1'b0;
      AXIS_IN_TDATA = '0;
      AXIS_OUT_FD_TREADY = 1'b1;
      AXIS_OUT_MD_TREADY = 1'b1;
      FRAME_SIZE = 32'd1024;
      PACKET_SIZE = 32'd256;
      do_reset("rst0");

      // Single frame, four full packets, full throughput
      n_acc = 0; first_acc = -1;
      queue_frame(1024, 256);
      drain("t1", 200);
      check("t1_acc", n_acc, 16);
      check("t1_span", last_acc - first_acc, 15);
      check("t1_fcnt", FRAME_CNT, 1);

      // Short final packet, two frames back to back with no bubble
      FRAME_SIZE = 32'd640; PACKET_SIZE = 32'd256;
      n_acc = 0; first_acc = -1;
      queue_frame(640, 256);
      queue_frame(640, 256);
      drain("t2", 200);
      check("t2_acc", n_acc, 20);
      check("t2_span", last_acc - first_acc, 19);
      check("t2_fcnt", FRAME_CNT, 3);

      // Metadata backpressure stalls input at the fifth packet start
      FRAME_SIZE = 32'd4096; PACKET_SIZE = 32'd64;
      md_en = 1'b0;
      n_acc = 0;
      queue_frame(4096, 64);
      repeat (20) step();
      check("t3_acc", n_acc, 4);
      check("t3_rdy", AXIS_IN_TREADY, 0);
      check("t3_mdv", AXIS_OUT_MD_TVALID, 1);
      md_en = 1'b1;
      drain("t3", 1000);
      check("t3_fcnt", FRAME_CNT, 4);

      // Random FD backpressure over three frames
      FRAME_SIZE = 32'd1024; PACKET_SIZE = 32'd192;
      fd_rand = 1'b1;
      for (int f = 0; f < 3; f++) queue_frame(1024, 192);
      drain("t4", 2000);
      fd_rand = 1'b0;
      check("t4_fcnt", FRAME_CNT, 7);

      // Reset in the middle of packet 1, then a fresh frame restarts at frame 0
      FRAME_SIZE = 32'd1024; PACKET_SIZE = 32'd512;
      queue_frame(1024, 512);
      n_acc = 0;
      for (int n = 0; n < 200 && n_acc < 13; n++) step();
      check("t5_acc", n_acc, 13);
      do_reset("rst_mid");
      FRAME_SIZE = 32'd256; PACKET_SIZE = 32'd256;
      queue_frame(256, 256);
      drain("t5", 200);
      check("t5_fcnt", FRAME_CNT, 1);

      // Bad packet size locks the input until reset
      FRAME_SIZE = 32'd1024; PACKET_SIZE = 32'd100;
      stim_q.push_back({16{32'hdead_beef}});
      n_acc = 0;
      repeat (6) step();
      check("t6_err", CFG_ERR, 1);
      check("t6_rdy", AXIS_IN_TREADY, 0);
      PACKET_SIZE = 32'd256;
      repeat (10) step();
      check("t6_err_sticky", {CFG_ERR, AXIS_IN_TREADY}, 2'b10);
      check("t6_acc", n_acc, 0);
      do_reset("rst_err");
      FRAME_SIZE = 32'd128; PACKET_SIZE = 32'd64;
      queue_frame(128, 64);
      drain("t6", 200);
      check("t6_fcnt", FRAME_CNT, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
